// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational packed-lane ALU between two requesters.
// Latency: request accept to response valid = 2 cycles; one op in flight, issue interval >= 3 cycles.
// Backpressure: req ready only in IDLE; RESP holds result and alu_* registers until rsp ready.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready/a/b/width/saturate/lock   request channel N (N=0,1)
//   rspN_valid/ready/c               response channel N
//   alu_a/b/width/saturate -> ALU    registered operands and mode (width 11 folded to 10)
//   alu_c <- ALU                     combinational ALU result
// Optional feature: define ALU_ARB_LOCK_EN to honour reqN_lock (bounded by LOCK_MAX grants).
module alu_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_width,
  input  logic        req0_saturate,
  input  logic        req0_lock,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_width,
  input  logic        req1_saturate,
  input  logic        req1_lock,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_c,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_c,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_width,
  output logic        alu_saturate,
  input  logic [31:0] alu_c
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        owner;       // requester whose op is in flight
  logic        last_grant;  // loser of the next tie is this requester
  logic        rsp_vld;
  logic [31:0] result_q;

  logic        grant;
  logic        lock_hold;   // a lock is held and its owner is presenting
  logic        accept;
  logic        own_rsp_ready;

`ifdef ALU_ARB_LOCK_EN
  localparam int CW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);

  logic          lock_vld;
  logic          lock_owner;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] lock_cnt_nxt;
  logic          sel_lock;

  assign lock_hold    = lock_vld && (lock_owner ? req1_valid : req0_valid);
  assign sel_lock     = grant ? req1_lock : req0_lock;
  // A locked grant to the current owner extends the run; anything else starts a new run.
  assign lock_cnt_nxt = (lock_vld && (lock_owner == grant)) ? lock_cnt + CW'(1) : CW'(1);
`else
  logic unused_lock;
  assign lock_hold   = 1'b0;
  assign unused_lock = req0_lock ^ req1_lock ^ (LOCK_MAX != 0);
`endif

  always_comb begin
    grant = ~last_grant;
    if (req0_valid && !req1_valid) grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
`ifdef ALU_ARB_LOCK_EN
    if (lock_hold) grant = lock_owner;
`endif
  end

  // Ready is gated by rst_n so it drops together with the registered outputs.
  assign req0_ready    = rst_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready    = rst_n && (state == IDLE) && req1_valid && grant;
  assign accept        = req0_ready || req1_ready;
  assign own_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  assign rsp0_valid = rsp_vld && !owner;
  assign rsp1_valid = rsp_vld && owner;
  assign rsp0_c     = owner ? 32'h0 : result_q;
  assign rsp1_c     = owner ? result_q : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      rsp_vld      <= 1'b0;
      result_q     <= 32'h0;
      alu_a        <= 32'h0;
      alu_b        <= 32'h0;
      alu_width    <= 2'b00;
      alu_saturate <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a        <= grant ? req1_a : req0_a;
            alu_b        <= grant ? req1_b : req0_b;
            alu_width    <= ((grant ? req1_width : req0_width) == 2'b11) ? 2'b10
                                                                         : (grant ? req1_width : req0_width);
            alu_saturate <= grant ? req1_saturate : req0_saturate;
            owner        <= grant;
            last_grant   <= grant;
            state        <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_c;
          rsp_vld  <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          if (own_rsp_ready) begin
            rsp_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld   <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
    end else if (state == IDLE) begin
      // Owner went away: release so the other requester is not starved.
      if (lock_vld && !lock_hold) begin
        lock_vld <= 1'b0;
        lock_cnt <= '0;
      end
      if (accept) begin
        if (sel_lock) begin
          // Run limit reached: release; last_grant already points at the owner,
          // so the next tie goes to the other requester.
          if (lock_cnt_nxt >= CW'(LOCK_MAX)) begin
            lock_vld <= 1'b0;
            lock_cnt <= '0;
          end else begin
            lock_vld   <= 1'b1;
            lock_owner <= grant;
            lock_cnt   <= lock_cnt_nxt;
          end
        end else if (lock_vld && (lock_owner == grant)) begin
          lock_vld <= 1'b0;
          lock_cnt <= '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req0_width = '0, req1_width = '0;
  logic        req0_saturate = 1'b0, req1_saturate = 1'b0;
  logic        req0_lock = 1'b0, req1_lock = 1'b0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_c, rsp1_c;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [1:0]  alu_width;
  logic        alu_saturate;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct { logic [31:0] c; int cyc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   gq[$];   // grant order
  int   gc[$];   // grant cycle

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_width(req0_width), .req0_saturate(req0_saturate), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_width(req1_width), .req1_saturate(req1_saturate), .req1_lock(req1_lock),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_width(alu_width), .alu_saturate(alu_saturate),
    .alu_c(alu_c)
  );

  // Reference packed-lane adder: signed lanes, optional saturation; width 11 means 32-bit.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] w, input logic sat);
    int lw;
    longint lim, ua, ub, s;
    logic [31:0] r;
    lw  = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
    lim = longint'(1) << (lw - 1);
    r   = '0;
    for (int l = 0; l < 32 / lw; l++) begin
      ua = longint'(a >> (l * lw)) & ((lim << 1) - 1);
      ub = longint'(b >> (l * lw)) & ((lim << 1) - 1);
      if (ua >= lim) ua = ua - (lim << 1);
      if (ub >= lim) ub = ub - (lim << 1);
      s = ua + ub;
      if (sat) begin
        if (s > lim - 1) s = lim - 1;
        if (s < -lim) s = -lim;
      end
      r = r | (32'(s & ((lim << 1) - 1)) << (l * lw));
    end
    return r;
  endfunction

  // ALU stand-in; an un-normalised width 11 yields a poison value.
  assign alu_c = (alu_width == 2'b11) ? 32'hDEADBEEF : alu_ref(alu_a, alu_b, alu_width, alu_saturate);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus-side scoreboard feed: record each handshake with its expected result.
  always @(negedge clk) begin
    if (rst_n && (req0_ready || req1_ready)) begin
      check("one_grant", {31'b0, req0_ready & req1_ready}, 32'h0);
      if (req0_valid && req0_ready) begin
        q0.push_back('{alu_ref(req0_a, req0_b, req0_width, req0_saturate), cyc});
        gq.push_back(0); gc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        q1.push_back('{alu_ref(req1_a, req1_b, req1_width, req1_saturate), cyc});
        gq.push_back(1); gc.push_back(cyc);
      end
    end
  end

  // Response monitor.
  logic        v0_prev = 1'b0, v1_prev = 1'b0, p0v = 1'b0, p1v = 1'b0;
  logic [31:0] p0c = '0, p1c = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete(); q1.delete();
      v0_prev = 1'b0; v1_prev = 1'b0; p0v = 1'b0; p1v = 1'b0;
    end else begin
      check("rsp_exclusive", {31'b0, rsp0_valid & rsp1_valid}, 32'h0);
      check("alu_width_not_11", {31'b0, alu_width == 2'b11}, 32'h0);
      if (rsp0_valid || rsp1_valid)
        check("req_ready_in_rsp", {30'b0, req1_ready, req0_ready}, 32'h0);
      if (p0v) begin
        check("rsp0_hold_valid", {31'b0, rsp0_valid}, 32'h1);
        check("rsp0_hold_c", rsp0_c, p0c);
      end
      if (p1v) begin
        check("rsp1_hold_valid", {31'b0, rsp1_valid}, 32'h1);
        check("rsp1_hold_c", rsp1_c, p1c);
      end
      if (rsp0_valid && !v0_prev) begin
        if (q0.size() == 0) check("rsp0_spurious", {31'b0, rsp0_valid}, 32'h0);
        else begin
          check("rsp0_latency", cyc - q0[0].cyc, 32'd2);
          check("rsp0_data", rsp0_c, q0[0].c);
        end
      end
      if (rsp1_valid && !v1_prev) begin
        if (q1.size() == 0) check("rsp1_spurious", {31'b0, rsp1_valid}, 32'h0);
        else begin
          check("rsp1_latency", cyc - q1[0].cyc, 32'd2);
          check("rsp1_data", rsp1_c, q1[0].c);
        end
      end
      if (rsp0_valid && rsp0_ready && q0.size() > 0) void'(q0.pop_front());
      if (rsp1_valid && rsp1_ready && q1.size() > 0) void'(q1.pop_front());
      p0v = rsp0_valid && !rsp0_ready; p0c = rsp0_c; v0_prev = rsp0_valid;
      p1v = rsp1_valid && !rsp1_ready; p1c = rsp1_c; v1_prev = rsp1_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(input int n, input logic lk);
    if (n == 0) begin
      req0_a = $urandom; req0_b = $urandom; req0_width = 2'($urandom_range(0, 3));
      req0_saturate = 1'($urandom_range(0, 1)); req0_lock = lk;
    end else begin
      req1_a = $urandom; req1_b = $urandom; req1_width = 2'($urandom_range(0, 3));
      req1_saturate = 1'($urandom_range(0, 1)); req1_lock = lk;
    end
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    gq.delete(); gc.delete();
  endtask

  // Present one op on requester n and return just after its accept edge.
  task automatic send(input int n, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] w, input logic s);
    if (n == 0) begin
      req0_a = a; req0_b = b; req0_width = w; req0_saturate = s; req0_lock = 1'b0; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_width = w; req1_saturate = s; req1_lock = 1'b0; req1_valid = 1'b1;
    end
    for (int i = 0; i < 50; i++) begin
      #1;
      if ((n == 0) ? req0_ready : req1_ready) begin
        tick();
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        return;
      end
      tick();
    end
    check("send_timeout", 32'h1, 32'h0);
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  initial begin
    int exp_lock[5];

    // Reset values, with valids asserted to show ready stays low in reset.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    check("rst_req0_ready", {31'b0, req0_ready}, 32'h0);
    check("rst_req1_ready", {31'b0, req1_ready}, 32'h0);
    check("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
    check("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
    check("rst_rsp0_c", rsp0_c, 32'h0);
    check("rst_rsp1_c", rsp1_c, 32'h0);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_alu_width", {30'b0, alu_width}, 32'h0);
    check("rst_alu_sat", {31'b0, alu_saturate}, 32'h0);
    do_reset();

    // Single saturating 4x8 op on requester 0.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    send(0, 32'h7F7F7F7F, 32'h01010101, 2'b00, 1'b1);
    check("single_exec_valid", {31'b0, rsp0_valid}, 32'h0);
    tick();
    check("single_rsp0_valid", {31'b0, rsp0_valid}, 32'h1);
    check("single_rsp0_c", rsp0_c, 32'h7F7F7F7F);
    check("single_rsp1_valid", {31'b0, rsp1_valid}, 32'h0);
    tick();

    // Width 11 from requester 1 must reach the ALU as 10.
    send(1, 32'h0000FFFF, 32'h00000001, 2'b11, 1'b0);
    check("w11_alu_width", {30'b0, alu_width}, 32'h2);
    tick(); tick();

    // Response stall for 10 cycles on requester 0, requester 1 waiting.
    rsp0_ready = 1'b0;
    send(0, 32'h12345678, 32'h11111111, 2'b01, 1'b0);
    rand_op(1, 1'b0); req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_req0_ready", {31'b0, req0_ready}, 32'h0);
      check("stall_req1_ready", {31'b0, req1_ready}, 32'h0);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    check("release_idle_req1_ready", {31'b0, req1_ready}, 32'h1);
    tick();
    req1_valid = 1'b0;
    repeat (3) tick();

    // Reset pulsed while a response is held.
    rsp0_ready = 1'b0;
    send(0, 32'hA5A5A5A5, 32'h01020304, 2'b10, 1'b1);
    tick();
    check("pre_reset_rsp0_valid", {31'b0, rsp0_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_rsp0_valid", {31'b0, rsp0_valid}, 32'h0);
    check("mid_reset_rsp0_c", rsp0_c, 32'h0);
    check("mid_reset_alu_a", alu_a, 32'h0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    gq.delete(); gc.delete();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Both requesters valid every cycle from reset: strict alternation, 3 cycles apart.
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_op(0, 1'b0); rand_op(1, 1'b0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    check("tie_count", {31'b0, gq.size() >= 6}, 32'h1);
    for (int i = 0; i < 6 && i < gq.size(); i++) begin
      check("tie_grant", gq[i], i % 2);
      if (i > 0) check("tie_interval", gc[i] - gc[i-1], 32'd3);
    end

    // Requester 0 asks for lock continuously while requester 1 waits.
    do_reset();
`ifdef ALU_ARB_LOCK_EN
    exp_lock = '{0, 0, 0, 0, 1};
`else
    exp_lock = '{0, 1, 0, 1, 0};
`endif
    req0_valid = 1'b1; req1_valid = 1'b1;
    rand_op(0, 1'b1); rand_op(1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      rand_op(0, 1'b1); rand_op(1, 1'b0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    check("lock_count", {31'b0, gq.size() >= 5}, 32'h1);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("lock_grant", gq[i], exp_lock[i]);

    // Random traffic with random backpressure and valid drops.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_op(0, 1'($urandom_range(0, 7) == 0));
      rand_op(1, 1'($urandom_range(0, 7) == 0));
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      rsp0_ready = ($urandom_range(0, 9) < 6);
      rsp1_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (8) tick();
    check("drain_q0_empty", q0.size(), 32'h0);
    check("drain_q1_empty", q1.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares one combinational packed-lane ALU (four 8-bit adder lanes, width modes 8/16/32, optional saturation) between two requesters. Each requester presents one operation per valid/ready handshake. The block grants round-robin, registers the operands into the ALU, captures the result and returns it on the winner's response channel with backpressure. It sits between the execution front-ends and the shared ALU instance.

## Interface
- LOCK_MAX, default 16: maximum consecutive locked grants to one owner before a forced release (only meaningful with ALU_ARB_LOCK_EN).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  requester N (N=0,1) has an operation.
- reqN_ready  out  1  arbiter accepts requester N this cycle.
- reqN_a, reqN_b  in  32  operands.
- reqN_width  in  2  lane mode: 00 = 4×8, 01 = 2×16, 10 = 1×32, 11 = treated as 10.
- reqN_saturate  in  1  saturating add.
- reqN_lock  in  1  hold grant after this op (ignored without ALU_ARB_LOCK_EN).
- rspN_valid  out  1  result for requester N is held.
- rspN_ready  in  1  requester N consumes the result.
- rspN_c  out  32  result.
- alu_a, alu_b  out  32  registered operands to the ALU.
- alu_width  out  2  registered lane mode; never 11.
- alu_saturate  out  1  registered saturate flag.
- alu_c  in  32  combinational ALU result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Compute grant g. Only one requester valid: g = that requester. Both valid: g = requester not in last_grant.
  - reqg_ready = 1, other ready = 0 (combinational from valid and state).
  - On handshake: latch a, b, width (11→10) and saturate into alu_* registers; latch owner = g; last_grant = g; go to EXEC.
  - No requester valid: stay in IDLE, all ready = 0.
- EXEC: result register ← alu_c; rspowner_valid = 1; go to RESP. All req ready = 0.
- RESP: rspowner_c = result register, held stable while rspowner_valid && !rspowner_ready. On rspowner_ready: rspowner_valid = 0, go to IDLE. All req ready = 0. Other rsp channel stays 0 throughout.
- Exactly one rsp valid at a time. Result is never dropped or duplicated.
- Arithmetic is entirely in the ALU. The arbiter only forwards the mode fields and does not alter data.

## Timing
- Reset: state = IDLE; last_grant = 1 (requester 0 wins the first tie); all ready/valid = 0; rsp*_c, alu_a, alu_b = 0; alu_width = 00; alu_saturate = 0; lock state cleared.
- Handshake at edge T → alu_* valid after T → result captured at T+1 → rsp valid after T+1.
- Minimum latency: request accept to response visible = 2 cycles.
- Minimum issue interval: 3 cycles (accept, EXEC, RESP with ready = 1).
- Ready depends on valid. Valid must not depend on ready.
- Requester may drop valid before handshake; no effect.
- Response back-pressure: arbitrary stall length in RESP; alu_* registers hold.
- Reset asserted mid-operation (EXEC or RESP): pending op discarded, no response issued, outputs go to reset values immediately.

## Configuration
- ALU_ARB_LOCK_EN defined:
  - An accepted request with reqN_lock = 1 sets lock owner = N.
  - While locked, IDLE grants only the owner; the other requester waits even if valid.
  - Lock clears on an accepted owner request with lock = 0, or when the owner is not valid in IDLE.
  - A counter tracks consecutive locked grants; on reaching LOCK_MAX, the lock force-clears and last_grant favours the other requester.
- ALU_ARB_LOCK_EN undefined: reqN_lock ports exist but are ignored; pure round-robin; no counter logic.

## Test plan
- Single op: req0 a = 0x7F7F7F7F, b = 0x01010101, width = 00, sat = 1 → after 2 cycles rsp0_c = ALU output (0x7F7F7F7F); rsp1_valid stays 0.
- Both valid every cycle from reset, rsp ready held 1 → grants alternate 0,1,0,1; each accept 3 cycles apart.
- req1 width = 11 → alu_width = 10 observed in EXEC.
- rsp0_ready held 0 for 10 cycles → rsp0_c stable, req0/req1 ready = 0 throughout; release → IDLE next cycle.
- Reset pulsed during RESP → rsp0_valid = 0 immediately; next tie is granted to requester 0.
- With ALU_ARB_LOCK_EN, LOCK_MAX = 4, req0 lock = 1 continuously, req1 valid → four req0 grants, then req1 granted.
